// File: rtl/stepper_pkg.sv
// Shared types and defaults for the stepper command path: FSM states,
// direction encoding and the default parameter values.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ISSUE  = 2'd2
  } state_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam int DEF_CNT_W            = 8;
  localparam int DEF_MAX_PENDING      = 100;
  localparam int DEF_DIR_SETUP_CYCLES = 50;

  // Direction implied by a nonzero signed count, taken from its sign bit.
  function automatic logic sign_dir(input logic msb);
    return msb ? DIR_CCW : DIR_CW;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times the DIR setup interval after a direction reversal.
// A load restarts the interval; done is high once the count reaches zero.
module settle_timer
  import stepper_pkg::*;
#(
  parameter int CYCLES = DEF_DIR_SETUP_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int TW = $clog2(CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(CYCLES - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/step_cmd_queue.sv
// Accumulates cw/ccw step requests into a signed saturating pending count and
// meters them out over a valid/ready interface, with DIR setup on reversals.
module step_cmd_queue
  import stepper_pkg::*;
#(
  parameter int CNT_W            = DEF_CNT_W,
  parameter int MAX_PENDING      = DEF_MAX_PENDING,
  parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cw_in,
  input  logic                    ccw_in,
  input  logic                    clear,
  input  logic                    cmd_ready,
  output logic                    cmd_valid,
  output logic                    cmd_dir,
  output logic signed [CNT_W-1:0] pending,
  output logic                    overflow,
  output logic                    busy
);

  localparam int EW = CNT_W + 2;
  localparam logic signed [EW-1:0]    ONE_W = EW'(1);
  localparam logic signed [EW-1:0]    MAX_W = EW'(MAX_PENDING);
  localparam logic signed [CNT_W-1:0] MAX_P = CNT_W'(MAX_PENDING);

  state_e state_q, state_d;
  logic signed [CNT_W-1:0] pending_q, pending_d;
  logic cmd_dir_q, cmd_dir_d;
  logic last_dir_q, last_dir_d;
  logic overflow_q, overflow_d;

  logic commit;
  logic tmr_load, tmr_dec, tmr_done;
  logic pend_nz, pend_dir;

  logic signed [EW-1:0] in_delta, com_delta, sum_w;

  assign pend_nz  = (pending_q != '0);
  assign pend_dir = sign_dir(pending_q[CNT_W-1]);

  settle_timer #(
    .CYCLES(DIR_SETUP_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .load_i(tmr_load),
    .dec_i (tmr_dec),
    .done_o(tmr_done)
  );

  // A commit is only ever raised when pend_dir matches the direction being
  // driven, so the committed step always moves pending toward zero.
  always_comb begin
    state_d    = state_q;
    cmd_dir_d  = cmd_dir_q;
    last_dir_d = last_dir_q;
    commit     = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_nz) begin
          if (pend_dir == last_dir_q) begin
            state_d = ISSUE;
            commit  = 1'b1;
          end else begin
            state_d    = SETTLE;
            cmd_dir_d  = pend_dir;
            last_dir_d = pend_dir;
            tmr_load   = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (pend_nz && (pend_dir != last_dir_q)) begin
          cmd_dir_d  = pend_dir;
          last_dir_d = pend_dir;
          tmr_load   = 1'b1;
        end else if (tmr_done) begin
          if (pend_nz) begin
            state_d = ISSUE;
            commit  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ISSUE: begin
        if (cmd_ready) begin
          if (pend_nz && (pend_dir == cmd_dir_q)) begin
            commit = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Counter datapath: inputs and the commit are summed in a wider signed
  // word so the clamp sees the true result before it is truncated.
  always_comb begin
    in_delta = '0;
    if (cw_in && !ccw_in) begin
      in_delta = ONE_W;
    end else if (!cw_in && ccw_in) begin
      in_delta = -ONE_W;
    end

    com_delta = '0;
    if (commit) begin
      com_delta = (pend_dir == DIR_CW) ? ONE_W : -ONE_W;
    end

    sum_w      = $signed({{2{pending_q[CNT_W-1]}}, pending_q}) + in_delta - com_delta;
    pending_d  = sum_w[CNT_W-1:0];
    overflow_d = overflow_q;

    if (clear) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else if (sum_w > MAX_W) begin
      pending_d  = MAX_P;
      overflow_d = 1'b1;
    end else if (sum_w < -MAX_W) begin
      pending_d  = -MAX_P;
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      cmd_dir_q  <= DIR_CW;
      last_dir_q <= DIR_CW;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cmd_dir_q  <= cmd_dir_d;
      last_dir_q <= last_dir_d;
      overflow_q <= overflow_d;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_dir   = cmd_dir_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE) || pend_nz;

  // An offered command must stay offered, with a steady direction, until taken.
  a_valid_hold: assert property (@(posedge clk) disable iff (reset)
    (cmd_valid && !cmd_ready) |=> (cmd_valid && $stable(cmd_dir)));

endmodule

// File: tb/tb_step_cmd_queue.sv
// Directed self-checking bench for step_cmd_queue: a per-cycle vector table
// for the basic cw flow plus hand-written multi-cycle corner sequences.
module tb_step_cmd_queue;

  logic clk;
  logic reset;
  logic cw_in, ccw_in, clear, cmd_ready;
  logic cmd_valid, cmd_dir, overflow, busy;
  logic signed [7:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic cw;
    logic ccw;
    logic clr;
    logic rdy;
    logic eValid;
    logic eDir;
    int   ePending;
    logic eOvf;
    logic eBusy;
  } vec_t;

  vec_t vecs[16];

  step_cmd_queue dut (
    .clk      (clk),
    .reset    (reset),
    .cw_in    (cw_in),
    .ccw_in   (ccw_in),
    .clear    (clear),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .pending  (pending),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then land 1 ns after the capturing edge.
  task automatic applyStimulus(input logic cw, input logic ccw,
                               input logic clr, input logic rdy);
    cw_in     = cw;
    ccw_in    = ccw;
    clear     = clr;
    cmd_ready = rdy;
    tick();
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic v, input logic d,
                          input int p, input logic o, input logic b);
    checkOutput({name, ".valid"},    int'(cmd_valid), int'(v));
    checkOutput({name, ".dir"},      int'(cmd_dir),   int'(d));
    checkOutput({name, ".pending"},  int'(pending),   p);
    checkOutput({name, ".overflow"}, int'(overflow),  int'(o));
    checkOutput({name, ".busy"},     int'(busy),      int'(b));
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int xfers;
    int lowCycles;
    int dirBad;
    int sawValid;

    //            cw ccw clr rdy  v  d  p  o  b
    vecs[0]  = '{1, 0, 0, 1,   0, 1, 1, 0, 1};
    vecs[1]  = '{0, 0, 0, 1,   1, 1, 0, 0, 1};
    vecs[2]  = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 1,   0, 1, 1, 0, 1};
    vecs[6]  = '{0, 0, 0, 1,   1, 1, 0, 0, 1};
    vecs[7]  = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 1,   0, 1, 1, 0, 1};
    vecs[11] = '{0, 0, 0, 1,   1, 1, 0, 0, 1};
    vecs[12] = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[13] = '{1, 1, 0, 1,   0, 1, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 1,   0, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 1, 1,   0, 1, 0, 0, 0};

    cw_in = 1'b0; ccw_in = 1'b0; clear = 1'b0; cmd_ready = 1'b0;
    doReset();
    checkAll("reset", 0, 1, 0, 0, 0);

    // Three spaced cw pulses, then a cancelling cw+ccw pair and a clear.
    xfers = 0;
    for (int i = 0; i < 16; i++) begin
      if (cmd_valid && vecs[i].rdy) xfers++;
      applyStimulus(vecs[i].cw, vecs[i].ccw, vecs[i].clr, vecs[i].rdy);
      checkAll($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eDir,
               vecs[i].ePending, vecs[i].eOvf, vecs[i].eBusy);
    end
    checkOutput("vec_transfers", xfers, 3);

    // Five cw pulses against a stalled sink, then drain back-to-back.
    applyStimulus(1, 0, 0, 0);
    checkAll("stall_p1", 0, 1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkAll("stall_p2", 1, 1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkAll("stall_p5", 1, 1, 4, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkAll("stall_hold", 1, 1, 4, 0, 1);
    xfers = 0;
    dirBad = 0;
    for (int i = 0; i < 20 && cmd_valid; i++) begin
      if (cmd_dir !== 1'b1) dirBad++;
      applyStimulus(0, 0, 0, 1);
      xfers++;
    end
    checkOutput("drain_transfers", xfers, 5);
    checkOutput("drain_dir_errors", dirBad, 0);
    checkAll("drain_end", 0, 1, 0, 0, 0);

    // Reversal to ccw: DIR setup interval before the first ccw command.
    applyStimulus(0, 1, 0, 1);
    checkAll("rev_p1", 0, 1, -1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkAll("rev_p2", 0, 0, -2, 0, 1);
    lowCycles = 0;
    dirBad = 0;
    for (int i = 0; i < 100 && !cmd_valid; i++) begin
      if (cmd_dir !== 1'b0) dirBad++;
      lowCycles++;
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("rev_low_cycles", lowCycles, 50);
    checkOutput("rev_settle_dir_errors", dirBad, 0);
    checkAll("rev_first_valid", 1, 0, -1, 0, 1);
    xfers = 0;
    dirBad = 0;
    for (int i = 0; i < 20 && cmd_valid; i++) begin
      if (cmd_dir !== 1'b0) dirBad++;
      applyStimulus(0, 0, 0, 1);
      xfers++;
    end
    checkOutput("rev_transfers", xfers, 2);
    checkOutput("rev_dir_errors", dirBad, 0);
    checkAll("rev_end", 0, 0, 0, 0, 0);

    // Saturation at +100 with a stalled sink, then clear.
    doReset();
    checkAll("sat_reset", 0, 1, 0, 0, 0);
    for (int n = 1; n <= 105; n++) begin
      applyStimulus(1, 0, 0, 0);
      if (n == 101) checkAll("sat_edge", 1, 1, 100, 0, 1);
    end
    checkAll("sat_full", 1, 1, 100, 1, 1);
    applyStimulus(0, 0, 1, 0);
    checkAll("sat_clear", 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkAll("sat_after_clear", 1, 1, 0, 0, 1);

    // Asynchronous reset while a command is offered with pending=3.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkAll("rst_pre", 1, 1, 3, 0, 1);
    cw_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkAll("rst_async", 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sawValid = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1);
      if (cmd_valid) sawValid++;
    end
    checkOutput("rst_no_issue", sawValid, 0);
    checkAll("rst_end", 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
